// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding/hazard scoreboard that owns the in-flight destination-tag pipe.
// Ports: ID-stage tags in, EX forward selects, load-use stall, stall counter.
module fwd_hazard_scoreboard #(
  parameter int REG_AW     = 5,
  parameter int RD_PORTS   = 2,
  parameter int STAGES     = 2,
  parameter int LOAD_STAGE = 2,
  parameter int CNT_W      = 16,
  localparam int SELW      = $clog2(STAGES + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       id_valid_i,
  input  logic [RD_PORTS*REG_AW-1:0] id_src_i,
  input  logic [REG_AW-1:0]          id_rd_i,
  input  logic                       id_regwrite_i,
  input  logic                       id_memread_i,
  input  logic                       flush_i,
  output logic                       stall_o,
  output logic [RD_PORTS*SELW-1:0]   fwd_sel_o,
  output logic [CNT_W-1:0]           stall_cnt_o
);

  logic              valid_q [STAGES+1];
  logic              valid_d [STAGES+1];
  logic              regw_q  [STAGES+1];
  logic              regw_d  [STAGES+1];
  logic              memrd_q [STAGES+1];
  logic              memrd_d [STAGES+1];
  logic [REG_AW-1:0] rd_q    [STAGES+1];
  logic [REG_AW-1:0] rd_d    [STAGES+1];
  logic [REG_AW-1:0] src_q   [RD_PORTS];
  logic [REG_AW-1:0] src_d   [RD_PORTS];
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  logic              wr [STAGES+1];
  logic              stall;
  logic              found;
  logic              ld_hit;
  logic              load;
  logic [SELW-1:0]   sel;
  logic [RD_PORTS*SELW-1:0] fwd;

  // $0 is hard-wired, so it can never be a forwarding source
  always_comb begin
    for (int k = 0; k <= STAGES; k++) begin
      wr[k] = valid_q[k] && regw_q[k] && (rd_q[k] != '0);
    end
  end

  // Only the youngest matching writer decides; an older load
  // shadowed by a younger ALU writer is harmless.
  always_comb begin
    stall  = 1'b0;
    found  = 1'b0;
    ld_hit = 1'b0;
    for (int p = 0; p < RD_PORTS; p++) begin
      found  = 1'b0;
      ld_hit = 1'b0;
      for (int j = 0; j < STAGES; j++) begin
        if (!found && wr[j] &&
            rd_q[j] == id_src_i[p*REG_AW +: REG_AW]) begin
          found  = 1'b1;
          ld_hit = memrd_q[j] && (j + 1 < LOAD_STAGE);
        end
      end
      if (id_valid_i && ld_hit) stall = 1'b1;
    end
    if (flush_i) stall = 1'b0;
  end

  // Scan oldest to youngest so the youngest match overwrites
  always_comb begin
    fwd = '0;
    sel = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      sel = '0;
      for (int k = STAGES; k >= 1; k--) begin
        if (wr[k] && rd_q[k] == src_q[p]) sel = SELW'(k);
      end
      if (!valid_q[0]) sel = '0;
      fwd[p*SELW +: SELW] = sel;
    end
  end

  always_comb begin
    load = id_valid_i && !stall && !flush_i;
    for (int k = 1; k <= STAGES; k++) begin
      valid_d[k] = valid_q[k-1];
      regw_d[k]  = regw_q[k-1];
      memrd_d[k] = memrd_q[k-1];
      rd_d[k]    = rd_q[k-1];
    end
    valid_d[0] = load;
    regw_d[0]  = load && id_regwrite_i;
    memrd_d[0] = load && id_memread_i;
    rd_d[0]    = load ? id_rd_i : '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      src_d[p] = load ? id_src_i[p*REG_AW +: REG_AW] : '0;
    end
    cnt_d = cnt_q;
    if (stall && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k <= STAGES; k++) begin
        valid_q[k] <= 1'b0;
        regw_q[k]  <= 1'b0;
        memrd_q[k] <= 1'b0;
        rd_q[k]    <= '0;
      end
      for (int p = 0; p < RD_PORTS; p++) src_q[p] <= '0;
      cnt_q <= '0;
    end else begin
      for (int k = 0; k <= STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        regw_q[k]  <= regw_d[k];
        memrd_q[k] <= memrd_d[k];
        rd_q[k]    <= rd_d[k];
      end
      for (int p = 0; p < RD_PORTS; p++) src_q[p] <= src_d[p];
      cnt_q <= cnt_d;
    end
  end

  assign stall_o     = stall;
  assign fwd_sel_o   = fwd;
  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Scoreboard bench for fwd_hazard_scoreboard: default, 4/3 and 7/7 configs.
// Expectations are queued per cycle and compared at the falling edge.
module tb_fwd_hazard_scoreboard;

  typedef struct packed {
    logic [1:0]  inst;
    logic        stall;
    logic [7:0]  fwd;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b1;
  logic        a_v = 1'b0, a_rw = 1'b0, a_mr = 1'b0, a_fl = 1'b0;
  logic [9:0]  a_src = '0;
  logic [4:0]  a_rd = '0;
  logic        a_stall;
  logic [3:0]  a_fwd;
  logic [15:0] a_cnt;

  logic        rst_b = 1'b1;
  logic        b_v = 1'b0, b_rw = 1'b0, b_mr = 1'b0, b_fl = 1'b0;
  logic [9:0]  b_src = '0;
  logic [4:0]  b_rd = '0;
  logic        b_stall, c_stall;
  logic [5:0]  b_fwd, c_fwd;
  logic [15:0] b_cnt, c_cnt;

  fwd_hazard_scoreboard u_a (
    .clk_i(clk), .rst_i(rst_a), .id_valid_i(a_v), .id_src_i(a_src),
    .id_rd_i(a_rd), .id_regwrite_i(a_rw), .id_memread_i(a_mr),
    .flush_i(a_fl), .stall_o(a_stall), .fwd_sel_o(a_fwd),
    .stall_cnt_o(a_cnt)
  );

  fwd_hazard_scoreboard #(.STAGES(4), .LOAD_STAGE(3)) u_b (
    .clk_i(clk), .rst_i(rst_b), .id_valid_i(b_v), .id_src_i(b_src),
    .id_rd_i(b_rd), .id_regwrite_i(b_rw), .id_memread_i(b_mr),
    .flush_i(b_fl), .stall_o(b_stall), .fwd_sel_o(b_fwd),
    .stall_cnt_o(b_cnt)
  );

  fwd_hazard_scoreboard #(.STAGES(7), .LOAD_STAGE(7)) u_c (
    .clk_i(clk), .rst_i(rst_b), .id_valid_i(b_v), .id_src_i(b_src),
    .id_rd_i(b_rd), .id_regwrite_i(b_rw), .id_memread_i(b_mr),
    .flush_i(b_fl), .stall_o(c_stall), .fwd_sel_o(c_fwd),
    .stall_cnt_o(c_cnt)
  );

  int    n_chk = 0;
  int    n_fail = 0;
  exp_t  exp_q[$];
  string tag_q[$];
  exp_t  e;
  string t;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      case (e.inst)
        2'd0: begin
          chk({t, ".stall"}, 32'(a_stall), 32'(e.stall));
          chk({t, ".fwd"},   32'(a_fwd),   32'(e.fwd));
          chk({t, ".cnt"},   32'(a_cnt),   32'(e.cnt));
        end
        2'd1: begin
          chk({t, ".stall"}, 32'(b_stall), 32'(e.stall));
          chk({t, ".fwd"},   32'(b_fwd),   32'(e.fwd));
          chk({t, ".cnt"},   32'(b_cnt),   32'(e.cnt));
        end
        default: chk({t, ".cnt"}, 32'(c_cnt), 32'(e.cnt));
      endcase
    end
  end

  task automatic push(input int inst, input string tag, input bit es,
                      input bit [7:0] ef, input bit [15:0] ec);
    exp_t x;
    x.inst  = 2'(inst);
    x.stall = es;
    x.fwd   = ef;
    x.cnt   = ec;
    exp_q.push_back(x);
    tag_q.push_back(tag);
  endtask

  // Drive one ID slot for a cycle; expectations hold for that cycle
  task automatic drive(input int inst, input string tag, input bit v,
                       input bit [4:0] s0, input bit [4:0] s1,
                       input bit [4:0] rd, input bit rw, input bit mr,
                       input bit fl, input bit es, input bit [2:0] f0,
                       input bit [2:0] f1, input bit [15:0] ec);
    if (inst == 0) begin
      a_v = v; a_src = {s1, s0}; a_rd = rd;
      a_rw = rw; a_mr = mr; a_fl = fl;
      push(0, tag, es, {4'b0, f1[1:0], f0[1:0]}, ec);
    end else begin
      b_v = v; b_src = {s1, s0}; b_rd = rd;
      b_rw = rw; b_mr = mr; b_fl = fl;
      push(1, tag, es, {2'b0, f1, f0}, ec);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0;
    //      i tag       v  s0 s1 rd rw mr fl  st f0 f1 cnt
    drive(0, "a_rst",   0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    drive(0, "lw8",     1, 0, 0, 8, 1, 1, 0,  0, 0, 0, 0);
    rst_a = 1'b1;
    drive(0, "rst_mid", 1, 8, 8, 9, 1, 0, 0,  1, 0, 0, 0);
    rst_a = 1'b0;
    drive(0, "post_r",  1, 8, 8, 9, 1, 0, 0,  0, 0, 0, 0);
    drive(0, "no_fwd",  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    drive(0, "add3",    1, 1, 2, 3, 1, 0, 0,  0, 0, 0, 0);
    drive(0, "sub3",    1, 4, 5, 3, 1, 0, 0,  0, 0, 0, 0);
    drive(0, "use3a",   1, 3, 3, 10, 1, 0, 0, 0, 0, 0, 0);
    drive(0, "pri_1",   1, 3, 3, 11, 1, 0, 0, 0, 1, 1, 0);
    drive(0, "pri_2",   0, 0, 0, 0, 0, 0, 0,  0, 2, 2, 0);
    drive(0, "w0",      1, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0);
    drive(0, "use0",    1, 0, 0, 12, 1, 0, 0, 0, 0, 0, 0);
    drive(0, "r0_fwd",  1, 0, 0, 0, 1, 1, 0,  0, 0, 0, 0);
    drive(0, "r0_stl",  1, 0, 0, 13, 1, 0, 0, 0, 0, 0, 0);
    drive(0, "lw5",     1, 0, 0, 5, 1, 1, 0,  0, 0, 0, 0);
    drive(0, "lu_stl",  1, 2, 5, 6, 1, 0, 0,  1, 0, 0, 0);
    drive(0, "lu_rel",  1, 2, 5, 6, 1, 0, 0,  0, 0, 0, 1);
    drive(0, "lu_fwd",  0, 0, 0, 0, 0, 0, 0,  0, 0, 2, 1);
    drive(0, "lw5b",    1, 0, 0, 5, 1, 1, 0,  0, 0, 0, 1);
    drive(0, "flush",   1, 2, 5, 6, 1, 0, 1,  0, 0, 0, 1);
    drive(0, "fl_bub",  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);

    rst_b = 1'b0;
    push(2, "c_rst", 0, 0, 0);
    drive(1, "b_rst",   0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    drive(1, "lw7",     1, 0, 0, 7, 1, 1, 0,  0, 0, 0, 0);
    drive(1, "g_stl1",  1, 7, 1, 8, 1, 0, 0,  1, 0, 0, 0);
    drive(1, "g_stl2",  1, 7, 1, 8, 1, 0, 0,  1, 0, 0, 1);
    drive(1, "g_rel",   1, 7, 1, 8, 1, 0, 0,  0, 0, 0, 2);
    drive(1, "g_fwd3",  0, 0, 0, 0, 0, 0, 0,  0, 3, 0, 2);
    drive(1, "lw9",     1, 0, 0, 9, 1, 1, 0,  0, 0, 0, 2);
    drive(1, "add9",    1, 0, 0, 9, 1, 0, 0,  0, 0, 0, 2);
    drive(1, "shadow",  1, 9, 0, 4, 1, 0, 0,  0, 0, 0, 2);

    // Back-to-back dependent loads: the 7/7 instance stalls 6 of 7 cycles
    b_v = 1'b1; b_src = {5'd7, 5'd7}; b_rd = 5'd7;
    b_rw = 1'b1; b_mr = 1'b1; b_fl = 1'b0;
    repeat (77000) @(posedge clk);
    #1;
    push(2, "c_sat", 0, 0, 16'hFFFF);
    @(posedge clk);
    #1;
    chk("q_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
